// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional feature macro: BIN2BCD_SIGNED_EN (two's-complement input, sign output).
package bin2bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam bcd_digit_t ADD3_THRESHOLD = 4'd5;

  // Smallest digit count D with 10^D >= 2^bits, i.e. enough digits for any
  // magnitude below 2^bits.
  function automatic int unsigned min_digits(input int unsigned bits);
    longint unsigned lim;
    longint unsigned p;
    int unsigned     d;
    if (bits > 63) return 32'hFFFF_FFFF;
    lim = 64'd1 << bits;
    p   = 64'd1;
    d   = 0;
    while (p < lim) begin
      p = p * 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Combinational add-3 correction cell for one BCD digit.
// Digits >= 5 get +3 (wrapping mod 16), everything else passes through.
module bcd_add3_digit
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  // Uniform correction, no special case for the unreachable codes 10-15.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= ADD3_THRESHOLD) digit_out = digit_in + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock,
// with a start/busy/done handshake.
// Optional feature macro: BIN2BCD_SIGNED_EN -- bin_in is two's complement,
// its magnitude is converted and sign_out reports the sign.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out
);

`ifdef BIN2BCD_SIGNED_EN
  // One extra shift-register bit so the magnitude of -2^(WIDTH-1) is exact.
  localparam int unsigned SW       = WIDTH + 1;
  localparam int unsigned MAG_BITS = WIDTH - 1;
`else
  localparam int unsigned SW       = WIDTH;
  localparam int unsigned MAG_BITS = WIDTH;
`endif
  localparam int unsigned CW = $clog2(SW);
  localparam int unsigned BW = 4 * DIGITS;

  if (WIDTH < 2) begin : g_width_chk
    $error("bin2bcd_seq: WIDTH must be at least 2");
  end
  if (DIGITS < min_digits(MAG_BITS)) begin : g_digits_chk
    $error("bin2bcd_seq: DIGITS too small to hold the largest input value");
  end

  state_t          state, state_nx;
  logic [SW-1:0]   bin_sr;
  logic [SW-1:0]   load_val;
  logic [BW-1:0]   bcd_acc;
  logic [BW-1:0]   bcd_corr;
  logic [BW-1:0]   bcd_next;
  logic [CW-1:0]   cnt;
  logic            load;
  logic            step;
  logic            last_step;

`ifdef BIN2BCD_SIGNED_EN
  logic [WIDTH:0]  ext;
  logic            sign_sr;

  // Sign-extend one bit, then take the absolute value at WIDTH+1 bits.
  always_comb begin
    ext      = {bin_in[WIDTH-1], bin_in};
    load_val = ext[WIDTH] ? (~ext + SW'(1)) : ext;
  end
`else
  assign load_val = bin_in;
`endif

  // One add-3 cell per digit, all applied before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_in  (bcd_acc[4*g +: 4]),
      .digit_out (bcd_corr[4*g +: 4])
    );
  end

  assign bcd_next = {bcd_corr[BW-2:0], bin_sr[SW-1]};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    last_step = step && (cnt == '0);
  end

  // Shift register, counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_sr  <= '0;
      bcd_acc <= '0;
      cnt     <= '0;
      bcd_out <= '0;
`ifdef BIN2BCD_SIGNED_EN
      sign_sr  <= 1'b0;
      sign_out <= 1'b0;
`endif
    end else if (load) begin
      bin_sr  <= load_val;
      bcd_acc <= '0;
      cnt     <= CW'(SW - 1);
`ifdef BIN2BCD_SIGNED_EN
      sign_sr <= bin_in[WIDTH-1];
`endif
    end else if (step) begin
      bcd_acc <= bcd_next;
      bin_sr  <= {bin_sr[SW-2:0], 1'b0};
      cnt     <= cnt - CW'(1);
      if (last_step) begin
        bcd_out <= bcd_next;
`ifdef BIN2BCD_SIGNED_EN
        sign_out <= sign_sr;
`endif
      end
    end
  end

`ifndef BIN2BCD_SIGNED_EN
  assign sign_out = 1'b0;
`endif

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- One bit is processed per clock, with an add-3 correction on every BCD digit before each shift.
- Generalises the single-digit add-3 correction cell to N-bit inputs and D digits, with a start/busy/done handshake.
- Sits between arithmetic datapaths and 7-segment display drivers.

Parameters:
- WIDTH, 8, binary input width in bits (≥2).
- DIGITS, 3, number of BCD output digits. Elaboration error if 10^DIGITS < 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of bin_in; sampled only when not busy.
- bin_in  input  WIDTH  binary operand; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out is updated.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0]. Holds until the next done.
- sign_out  output  1  result sign (feature macro only; constant 0 otherwise).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, sign_out=0, internal shift register and counter cleared. Takes effect immediately, including mid-conversion; the aborted result is never presented.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge loads the binary shift register with bin_in, clears the BCD accumulator, sets the bit counter to WIDTH-1 and moves to SHIFT.
- SHIFT:
  - busy=1.
  - Each edge: every digit ≥5 gets +3, with the result truncated to 4 bits. The combined {BCD, binary} register then shifts left 1, with the binary MSB entering the BCD LSB.
  - The counter decrements. The step taken with counter=0 is the last; the next state is DONE.
  - start is ignored throughout SHIFT.
- DONE:
  - Lasts one cycle; done=1, busy=0.
  - bcd_out and sign_out are registered on the edge entering DONE.
  - At the DONE→next edge: start=1 begins a new conversion (load as in IDLE, go to SHIFT); otherwise go to IDLE.
- Latency: with start accepted at edge E0, busy is high for WIDTH cycles. done is high in the cycle after edge E0+WIDTH. The throughput floor is WIDTH+1 cycles per conversion.
- Digit correction is applied uniformly. Codes 10–15 are unreachable for legal parameters; the cell still maps them to value+3 mod 16 (no special case).
- bin_in changes after acceptance have no effect.

Optional Feature:
- BIN2BCD_SIGNED_EN defined:
  - bin_in is two's complement.
  - On acceptance, the magnitude (|bin_in|, computed at WIDTH+1 bits so -2^(WIDTH-1) is exact) is loaded.
  - sign_out is registered with bcd_out and is 1 iff bin_in was negative.
  - Shift count becomes WIDTH, so latency is WIDTH+1 cycles to done.
  - The DIGITS check uses 2^(WIDTH-1).
- Undefined: input is unsigned, sign_out is tied 0, and no magnitude logic is synthesised.

Decomposition:
- Package bin2bcd_pkg:
  - bcd_digit_t: 4-bit typedef.
  - State enum: IDLE/SHIFT/DONE.
  - Constant ADD3_THRESHOLD=5.
  - Function computing the minimum digit count for the elaboration check.
- Sub-module bcd_add3_digit: a purely combinational 4-bit correction cell, instantiated DIGITS times via generate.
- The top module holds the FSM, counter and shift register.

Test Plan:
- WIDTH=8, DIGITS=3, bin_in=8'd255, start pulse.
  - Required: busy high 8 cycles, then done pulse.
  - bcd_out=12'h255.
- bin_in=0.
  - Required: bcd_out=12'h000 and done after the same latency.
- Sequencing: convert 8'd99, then assert start while busy with bin_in=8'd7.
  - Required: start ignored; bcd_out=12'h099.
  - Then start held high through DONE with bin_in=8'd128.
  - Required: back-to-back conversion, second done gives 12'h128.
- Reset mid-conversion: assert reset=0 at SHIFT step 4 of bin_in=8'd200.
  - Required: outputs 0 immediately.
  - After release: IDLE, no done, bcd_out stays 0.
- WIDTH=16, DIGITS=5, bin_in=16'hFFFF.
  - Required: bcd_out=20'h65535 after 16 busy cycles.
  - Also sweep all 8-bit values against a reference model.
- BIN2BCD_SIGNED_EN, WIDTH=8: bin_in=8'h80.
  - Required: sign_out=1, bcd_out=12'h128.
  - bin_in=8'hFF → sign_out=1, bcd_out=12'h001.
  - bin_in=8'd127 → sign_out=0, bcd_out=12'h127.
